// File: rtl/nsc8_defs.sv
// ============================================================================
// Module  : nsc8_defs (package)
// Brief   : NSC-8 sequencer opcodes, micro-step encodings and strobe bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nsc8_defs;

    localparam int OP_W   = 4;
    localparam int STEP_W = 3;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_LDI = 4'h5;
    localparam opcode_t OP_JMP = 4'h6;
    localparam opcode_t OP_JC  = 4'h7;
    localparam opcode_t OP_JZ  = 4'h8;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    typedef enum logic [STEP_W-1:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic ir_out;
        logic ram_out;
        logic a_out;
        logic alu_out;
        logic mar_load;
        logic ir_load;
        logic ram_load;
        logic b_load;
        logic load_a;
        logic load_immediate_a;
        logic out_load;
        logic pc_load;
        logic flags_load;
        logic pc_inc;
        logic alu_sub;
    } strobes_t;

    // Final execute step of each opcode; everything not listed ends in T2.
    function automatic state_e last_step(input opcode_t op);
        case (op)
            OP_LDA, OP_STA: return ST_T3;
            OP_ADD, OP_SUB: return ST_T4;
            default:        return ST_T2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sequencer_decode.sv
// ============================================================================
// Module  : sequencer_decode
// Brief   : Combinational (state, opcode, flags) -> bus strobe map.
//           NSC8_COND_JUMP_EN enables JC/JZ; otherwise they decode as NOP.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sequencer_decode
    import nsc8_defs::*;
(
    input  state_e   state_i,
    input  opcode_t  opcode_i,
    input  logic     carry_i,
    input  logic     zero_i,
    output strobes_t strobes_o
);

`ifndef NSC8_COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = carry_i ^ zero_i;
`endif

    always_comb begin
        strobes_o = '0;
        case (state_i)
            ST_T0: begin
                strobes_o.pc_out   = 1'b1;
                strobes_o.mar_load = 1'b1;
            end
            ST_T1: begin
                strobes_o.ram_out = 1'b1;
                strobes_o.ir_load = 1'b1;
                strobes_o.pc_inc  = 1'b1;
            end
            ST_T2: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        strobes_o.ir_out   = 1'b1;
                        strobes_o.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        strobes_o.ir_out           = 1'b1;
                        strobes_o.load_immediate_a = 1'b1;
                    end
                    OP_JMP: begin
                        strobes_o.ir_out  = 1'b1;
                        strobes_o.pc_load = 1'b1;
                    end
`ifdef NSC8_COND_JUMP_EN
                    OP_JC: begin
                        strobes_o.ir_out  = carry_i;
                        strobes_o.pc_load = carry_i;
                    end
                    OP_JZ: begin
                        strobes_o.ir_out  = zero_i;
                        strobes_o.pc_load = zero_i;
                    end
`endif
                    OP_OUT: begin
                        strobes_o.a_out    = 1'b1;
                        strobes_o.out_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T3: begin
                case (opcode_i)
                    OP_LDA: begin
                        strobes_o.ram_out = 1'b1;
                        strobes_o.load_a  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        strobes_o.ram_out = 1'b1;
                        strobes_o.b_load  = 1'b1;
                    end
                    OP_STA: begin
                        strobes_o.a_out    = 1'b1;
                        strobes_o.ram_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    strobes_o.alu_out    = 1'b1;
                    strobes_o.load_a     = 1'b1;
                    strobes_o.flags_load = 1'b1;
                    strobes_o.alu_sub    = (opcode_i == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module  : control_sequencer
// Brief   : NSC-8 fetch/decode/execute sequencer; holds the micro-step state.
//           NSC8_COND_JUMP_EN (see sequencer_decode) enables JC/JZ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import nsc8_defs::*;
#(
    parameter int X = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [X/2-1:0]    ir_opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic              pc_out,
    output logic              ir_out,
    output logic              ram_out,
    output logic              a_out,
    output logic              alu_out,
    output logic              mar_load,
    output logic              ir_load,
    output logic              ram_load,
    output logic              b_load,
    output logic              load_a,
    output logic              load_immediate_a,
    output logic              out_load,
    output logic              pc_load,
    output logic              flags_load,
    output logic              pc_inc,
    output logic              alu_sub,
    output logic              halted,
    output logic [STEP_W-1:0] step
);

    state_e   state_q;
    state_e   state_d;
    opcode_t  w_op;
    strobes_t w_dec;
    strobes_t w_strb;

    assign w_op = ir_opcode[OP_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2: begin
                if (w_op == OP_HLT)
                    state_d = ST_HALT;
                else if (last_step(w_op) == ST_T2)
                    state_d = ST_T0;
                else
                    state_d = ST_T3;
            end
            ST_T3:   state_d = (last_step(w_op) == ST_T3) ? ST_T0 : ST_T4;
            ST_T4:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear)
            state_q <= ST_T0;
        else
            state_q <= state_d;
    end

    sequencer_decode u_decode (
        .state_i   (state_q),
        .opcode_i  (w_op),
        .carry_i   (carry_flag),
        .zero_i    (zero_flag),
        .strobes_o (w_dec)
    );

    // Clear masks the current step so an aborted instruction leaves no partial strobes.
    assign w_strb = clear ? '0 : w_dec;
    assign halted = ~clear & (state_q == ST_HALT);
    assign step   = clear ? '0 : state_q;

    assign pc_out           = w_strb.pc_out;
    assign ir_out           = w_strb.ir_out;
    assign ram_out          = w_strb.ram_out;
    assign a_out            = w_strb.a_out;
    assign alu_out          = w_strb.alu_out;
    assign mar_load         = w_strb.mar_load;
    assign ir_load          = w_strb.ir_load;
    assign ram_load         = w_strb.ram_load;
    assign b_load           = w_strb.b_load;
    assign load_a           = w_strb.load_a;
    assign load_immediate_a = w_strb.load_immediate_a;
    assign out_load         = w_strb.out_load;
    assign pc_load          = w_strb.pc_load;
    assign flags_load       = w_strb.flags_load;
    assign pc_inc           = w_strb.pc_inc;
    assign alu_sub          = w_strb.alu_sub;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module  : tb_control_sequencer
// Brief   : Self-checking bench for control_sequencer against an
//           instruction-level micro-step table model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear;
    logic [3:0] ir_opcode;
    logic       carry_flag, zero_flag;
    logic pc_out, ir_out, ram_out, a_out, alu_out, mar_load, ir_load, ram_load;
    logic b_load, load_a, load_immediate_a, out_load, pc_load, flags_load, pc_inc, alu_sub;
    logic       halted;
    logic [2:0] step;

    control_sequencer #(.X(8)) dut (
        .clk(clk), .clear(clear), .ir_opcode(ir_opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_out(pc_out), .ir_out(ir_out), .ram_out(ram_out), .a_out(a_out),
        .alu_out(alu_out), .mar_load(mar_load), .ir_load(ir_load),
        .ram_load(ram_load), .b_load(b_load), .load_a(load_a),
        .load_immediate_a(load_immediate_a), .out_load(out_load),
        .pc_load(pc_load), .flags_load(flags_load), .pc_inc(pc_inc),
        .alu_sub(alu_sub), .halted(halted), .step(step)
    );

`ifdef NSC8_COND_JUMP_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    localparam logic [15:0] S_PCO = 16'h8000, S_IRO = 16'h4000, S_RAMO = 16'h2000,
                            S_AO  = 16'h1000, S_ALUO = 16'h0800, S_MAR = 16'h0400,
                            S_IRL = 16'h0200, S_RAML = 16'h0100, S_BL  = 16'h0080,
                            S_LA  = 16'h0040, S_LI  = 16'h0020, S_OL  = 16'h0010,
                            S_PL  = 16'h0008, S_FL  = 16'h0004, S_PCI = 16'h0002,
                            S_SUB = 16'h0001;

    typedef logic [15:0] mq_t[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_idx    = 0;
    bit          m_halt   = 1'b0;
    logic [3:0]  m_op     = 4'h0;
    mq_t         m_body;
    logic [19:0] m_exp, m_mask;
    logic        cur_clr;

    function automatic logic [19:0] observed();
        return {pc_out, ir_out, ram_out, a_out, alu_out, mar_load, ir_load, ram_load,
                b_load, load_a, load_immediate_a, out_load, pc_load, flags_load,
                pc_inc, alu_sub, halted, step};
    endfunction

    // Execute-phase strobe list per instruction, one entry per step from T2.
    function automatic mq_t body(input logic [3:0] op, input logic c, input logic z);
        mq_t q;
        case (op)
            4'h1: begin q.push_back(S_IRO | S_MAR); q.push_back(S_RAMO | S_LA); end
            4'h2: begin q.push_back(S_IRO | S_MAR); q.push_back(S_RAMO | S_BL);
                        q.push_back(S_ALUO | S_LA | S_FL); end
            4'h3: begin q.push_back(S_IRO | S_MAR); q.push_back(S_RAMO | S_BL);
                        q.push_back(S_ALUO | S_LA | S_FL | S_SUB); end
            4'h4: begin q.push_back(S_IRO | S_MAR); q.push_back(S_AO | S_RAML); end
            4'h5: q.push_back(S_IRO | S_LI);
            4'h6: q.push_back(S_IRO | S_PL);
            4'h7: q.push_back((COND_EN && c) ? (S_IRO | S_PL) : 16'h0);
            4'h8: q.push_back((COND_EN && z) ? (S_IRO | S_PL) : 16'h0);
            4'hE: q.push_back(S_AO | S_OL);
            default: q.push_back(16'h0);
        endcase
        return q;
    endfunction

    task automatic model_eval(input logic clr, input logic [3:0] op, input logic c, input logic z);
        m_mask = 20'hFFFFF;
        if (clr)
            m_exp = 20'h0;
        else if (m_halt) begin
            m_exp  = {16'h0, 1'b1, 3'd0};
            m_mask = 20'hFFFF8;
        end else if (m_idx == 0)
            m_exp = {S_PCO | S_MAR, 1'b0, 3'd0};
        else if (m_idx == 1)
            m_exp = {S_RAMO | S_IRL | S_PCI, 1'b0, 3'd1};
        else begin
            if (m_idx == 2) begin
                m_op   = op;
                m_body = body(op, c, z);
            end
            m_exp = {m_body[m_idx-2], 1'b0, 3'(m_idx)};
        end
    endtask

    task automatic drive(input logic clr, input logic [3:0] op, input logic c, input logic z);
        @(negedge clk);
        clear = clr; ir_opcode = op; carry_flag = c; zero_flag = z;
        cur_clr = clr;
        #1;
        model_eval(clr, op, c, z);
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_clr) begin
            m_idx  = 0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_idx >= 2 && (m_idx - 2) == m_body.size() - 1) begin
                m_idx = 0;
                if (m_op == 4'hF) m_halt = 1'b1;
            end else
                m_idx++;
        end
    endtask

    function automatic logic [3:0] held_op(input logic [3:0] op);
        return (m_idx >= 2) ? op : 4'($urandom_range(0, 15));
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
            n_checks++;
            if ((observed() & m_mask) !== (m_exp & m_mask))
                $display("FAIL reset_clear%0d: got %h expected %h", i, observed(), m_exp);
            else n_pass++;
            tick();
        end
        drive(1'b0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        n_checks++;
        if (observed() !== {S_PCO | S_MAR, 1'b0, 3'd0})
            $display("FAIL reset_first_t0: got %h expected %h", observed(), {S_PCO | S_MAR, 4'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_add();
        drive(1'b1, 4'h2, 1'b0, 1'b0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'h2, 1'($urandom), 1'($urandom));
            n_checks++;
            if ((observed() & m_mask) !== (m_exp & m_mask))
                $display("FAIL add_cycle%0d: got %h expected %h", i, observed(), m_exp);
            else n_pass++;
            n_checks++;
            if (alu_sub !== 1'b0)
                $display("FAIL add_alu_sub%0d: got %b expected 0", i, alu_sub);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_cond_jump(input logic [3:0] op);
        for (int f = 1; f >= 0; f--) begin
            drive(1'b1, op, 1'b0, 1'b0); tick();
            for (int i = 0; i < 4; i++) begin
                // Flag is only meaningful in T2; other steps see the inverse.
                drive(1'b0, op, (i == 2) ? 1'(f) : 1'(!f), (i == 2) ? 1'(f) : 1'(!f));
                n_checks++;
                if ((observed() & m_mask) !== (m_exp & m_mask))
                    $display("FAIL jump%h_flag%0d_cycle%0d: got %h expected %h",
                             op, f, i, observed(), m_exp);
                else n_pass++;
                tick();
            end
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 4'hF, 1'b0, 1'b0); tick();
        for (int i = 0; i < 23; i++) begin
            drive(1'b0, 4'hF, 1'($urandom), 1'($urandom));
            n_checks++;
            if ((observed() & m_mask) !== (m_exp & m_mask))
                $display("FAIL halt_cycle%0d: got %h expected %h", i, observed(), m_exp);
            else n_pass++;
            tick();
        end
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== 20'h0)
            $display("FAIL halt_clear: got %h expected 00000", observed());
        else n_pass++;
        tick();
        drive(1'b0, 4'hF, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== {S_PCO | S_MAR, 4'd0})
            $display("FAIL halt_exit_t0: got %h expected %h", observed(), {S_PCO | S_MAR, 4'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_sta_abort();
        drive(1'b1, 4'h4, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h4, 1'b0, 1'b0);
            n_checks++;
            if ((observed() & m_mask) !== (m_exp & m_mask))
                $display("FAIL sta_cycle%0d: got %h expected %h", i, observed(), m_exp);
            else n_pass++;
            tick();
        end
        drive(1'b1, 4'h4, 1'b0, 1'b0);
        n_checks++;
        if (ram_load !== 1'b0 || observed() !== 20'h0)
            $display("FAIL sta_abort_t3: got %h expected 00000", observed());
        else n_pass++;
        tick();
        drive(1'b0, 4'h4, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== {S_PCO | S_MAR, 4'd0} || ram_load !== 1'b0)
            $display("FAIL sta_abort_next: got %h expected %h", observed(), {S_PCO | S_MAR, 4'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] op, cur;
        logic       clr;
        int         bad = 0;
        cur = 4'h0;
        for (int i = 0; i < 1000; i++) begin
            clr = ($urandom_range(0, 63) == 0);
            if (m_idx == 2) begin
                do op = 4'($urandom_range(0, 15)); while (op == 4'hF);
                cur = op;
            end
            drive(clr, held_op(cur), 1'($urandom), 1'($urandom));
            if ((observed() & m_mask) !== (m_exp & m_mask)) begin
                if (bad < 5)
                    $display("FAIL random_cycle%0d: got %h expected %h", i, observed(), m_exp);
                bad++;
            end
            if (!$onehot0({pc_out, ir_out, ram_out, a_out, alu_out})) begin
                if (bad < 5)
                    $display("FAIL random_bus%0d: drivers %b expected one-hot-or-zero", i,
                             {pc_out, ir_out, ram_out, a_out, alu_out});
                bad++;
            end
            tick();
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL random_summary: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        clear = 1'b1; ir_opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0; cur_clr = 1'b1;
        test_reset();
        test_add();
        test_cond_jump(4'h7);
        test_cond_jump(4'h8);
        test_halt();
        test_sta_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
